// File: rtl/chebyshev_openmp_sdiv_28s_16s_seq_if.sv
// chebyshev_openmp_sdiv_28s_16s_seq_if: start/done handshake and operand/result bus of the signed divider
interface chebyshev_openmp_sdiv_28s_16s_seq_if #(
   parameter int DIVIDEND_W = 28,
   parameter int DIVISOR_W  = 16
);
   logic                  ce;
   logic                  start;
   logic [DIVIDEND_W-1:0] dividend;
   logic [DIVISOR_W-1:0]  divisor;
   logic                  busy;
   logic                  done;
   logic [DIVIDEND_W-1:0] quotient;
   logic [DIVISOR_W-1:0]  remainder;
   logic                  div_by_zero;
   modport master (output ce, start, dividend, divisor,
                   input  busy, done, quotient, remainder, div_by_zero);
   modport slave  (input  ce, start, dividend, divisor,
                   output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/chebyshev_openmp_sdiv_28s_16s_seq.sv
// chebyshev_openmp_sdiv_28s_16s_seq: radix-2 restoring signed divider, C truncation, one quotient bit per enabled cycle
module chebyshev_openmp_sdiv_28s_16s_seq #(
   parameter int DIVIDEND_W = 28,
   parameter int DIVISOR_W  = 16
) (
   input logic ap_clk,
   input logic ap_rst,
   chebyshev_openmp_sdiv_28s_16s_seq_if.slave dv
);
   localparam int CW = $clog2(DIVIDEND_W);
   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
   state_t                state, state_nx;
   logic [CW-1:0]         cnt;
   logic [DIVIDEND_W-1:0] dq, a_abs, quotient;
   logic [DIVISOR_W-1:0]  pr, dmag, dlo, d_abs, remainder;
   logic [DIVISOR_W:0]    pr_sh, diff;
   logic                  sign_q, sign_r, zero, take, done, div_by_zero;
   // magnitudes fit unsigned in the native widths, including -2^(W-1)
   always_comb begin
      a_abs = dv.dividend[DIVIDEND_W-1] ? -dv.dividend : dv.dividend;
      d_abs = dv.divisor[DIVISOR_W-1] ? -dv.divisor : dv.divisor;
      pr_sh = {pr, dq[DIVIDEND_W-1]};
      diff  = pr_sh - {1'b0, dmag};
      take  = !diff[DIVISOR_W];
   end
   always_comb begin
      state_nx = !dv.ce ? state :
                 (state == IDLE) ? (dv.start ? RUN : IDLE) :
                 (state == RUN)  ? ((cnt == '0) ? FIX : RUN) : IDLE;
   end
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state       <= IDLE;
         cnt         <= '0;
         dq          <= '0;
         pr          <= '0;
         dmag        <= '0;
         dlo         <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         zero        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (dv.ce) begin
         state <= state_nx;
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (dv.start) begin
                  dq     <= a_abs;
                  pr     <= '0;
                  dmag   <= d_abs;
                  dlo    <= dv.dividend[DIVISOR_W-1:0];
                  sign_q <= dv.dividend[DIVIDEND_W-1] ^ dv.divisor[DIVISOR_W-1];
                  sign_r <= dv.dividend[DIVIDEND_W-1];
                  zero   <= (dv.divisor == '0);
                  cnt    <= CW'(DIVIDEND_W - 1);
               end
            end
            RUN: begin
               pr  <= take ? diff[DIVISOR_W-1:0] : pr_sh[DIVISOR_W-1:0];
               dq  <= {dq[DIVIDEND_W-2:0], take};
               cnt <= cnt - 1'b1;
            end
            FIX: begin
               done        <= 1'b1;
               div_by_zero <= zero;
               // divide by zero saturates toward the dividend's sign
               quotient    <= zero ? (sign_r ? {1'b1, {(DIVIDEND_W-1){1'b0}}} : {1'b0, {(DIVIDEND_W-1){1'b1}}}) :
                              sign_q ? -dq : dq;
               remainder   <= zero ? dlo : sign_r ? -pr : pr;
            end
            default: ;
         endcase
      end
   end
   assign dv.busy        = (state != IDLE);
   assign dv.done        = done;
   assign dv.quotient    = quotient;
   assign dv.remainder   = remainder;
   assign dv.div_by_zero = div_by_zero;
endmodule
